// File: rtl/csr_exec_unit.sv
// csr_exec_unit: two-stage CSR execute pipe (E1 operand fetch, E2 compute and
// broadcast) feeding an in-order buffer that holds CSR writes until commit.
module csr_exec_unit #(
  parameter int DEPTH = 4,
  parameter int PHY_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [129:0]     issue_pkt,
  output logic [PHY_W-1:0] prf_raddr,
  input  logic [31:0]      prf_rdata,
  output logic             CSR_result_valid,
  output logic [PHY_W-1:0] CSR_result_dest,
  output logic [31:0]      CSR_result_data,
  output logic [31:0]      CSR_result_inst_num,
  input  logic             commit_valid,
  input  logic [31:0]      commit_inst_num,
  input  logic             flush,
  output logic             csr_wr_en,
  output logic [11:0]      csr_wr_addr,
  output logic [31:0]      csr_wr_data,
  output logic             csr_busy,
  output logic             csr_overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic             valid;
    logic [PHY_W-1:0] op1;
    logic [31:0]      inst;
    logic [PHY_W-1:0] rd;
    logic [3:0]       aluop;
    logic             src2;
    logic [31:0]      csr_data;
    logic [11:0]      csr_addr;
    logic [31:0]      imm;
  } pkt_t;

  pkt_t pkt;
  assign pkt = issue_pkt;

  // vld_pipe_q[0]: E1 holds a packet; vld_pipe_q[1]: E2 result register valid
  logic [1:0]       vld_pipe_q;
  logic [31:0]      e1_inst_q, e1_csr_q;
  logic [PHY_W-1:0] e1_rd_q;
  logic [3:0]       e1_op_q;
  logic             e1_src2_q;
  logic [11:0]      e1_addr_q;
  logic [4:0]       e1_imm_q;
  logic [PHY_W-1:0] raddr_q;
  logic [PHY_W-1:0] res_dest_q;
  logic [31:0]      res_data_q, res_inst_q;
  logic             ovf_q;

  logic [31:0]      fifo_inst [DEPTH];
  logic [11:0]      fifo_addr [DEPTH];
  logic [31:0]      fifo_data [DEPTH];
  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    cnt_q;
  logic             wr_en_q;
  logic [11:0]      wr_addr_q;
  logic [31:0]      wr_data_q;

  logic             accept, enq, deq, do_wr;
  logic [31:0]      src, new_val;
  logic [CW:0]      occ;
  logic             unused_imm;

  // only the low five immediate bits form a CSR zimm operand
  assign unused_imm = ^pkt.imm[31:5];

  // Occupancy counts the result register too; that entry has already been
  // enqueued, so busy is slightly conservative but never lets the buffer overrun.
  assign occ      = {1'b0, cnt_q} + (CW+1)'(vld_pipe_q[0]) + (CW+1)'(vld_pipe_q[1]);
  assign csr_busy = occ >= (CW+1)'(DEPTH);
  assign accept   = pkt.valid & ~csr_busy & ~flush;

  // E2: operand select and new CSR value / write-enable decode
  always_comb begin
    src     = e1_src2_q ? {27'b0, e1_imm_q} : prf_rdata;
    new_val = src;
    do_wr   = 1'b0;
    case (e1_op_q)
      4'd0:    begin new_val = src;             do_wr = 1'b1; end
      4'd1:    begin new_val = e1_csr_q | src;  do_wr = |src; end
      4'd2:    begin new_val = e1_csr_q & ~src; do_wr = |src; end
      default: begin new_val = src;             do_wr = 1'b0; end
    endcase
  end

  assign enq = vld_pipe_q[0] & do_wr & ~flush;
  assign deq = commit_valid & ~flush & (cnt_q != '0) &
               (fifo_inst[head_q] == commit_inst_num);

  // E1 latch, E2 result register and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe_q <= '0;
      e1_inst_q  <= '0;
      e1_csr_q   <= '0;
      e1_rd_q    <= '0;
      e1_op_q    <= '0;
      e1_src2_q  <= 1'b0;
      e1_addr_q  <= '0;
      e1_imm_q   <= '0;
      raddr_q    <= '0;
      res_dest_q <= '0;
      res_data_q <= '0;
      res_inst_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0] & ~flush, accept};
      if (accept) begin
        e1_inst_q <= pkt.inst;
        e1_csr_q  <= pkt.csr_data;
        e1_rd_q   <= pkt.rd;
        e1_op_q   <= pkt.aluop;
        e1_src2_q <= pkt.src2;
        e1_addr_q <= pkt.csr_addr;
        e1_imm_q  <= pkt.imm[4:0];
        raddr_q   <= pkt.op1;
      end
      if (vld_pipe_q[0] & ~flush) begin
        res_dest_q <= e1_rd_q;
        res_data_q <= e1_csr_q;
        res_inst_q <= e1_inst_q;
      end
      if (pkt.valid & csr_busy) ovf_q <= 1'b1;
    end
  end

  // pending-write buffer pointers, count and architectural write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= deq;
      if (flush) begin
        head_q <= '0;
        tail_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (enq) tail_q <= tail_q + PW'(1);
        if (deq) begin
          head_q    <= head_q + PW'(1);
          wr_addr_q <= fifo_addr[head_q];
          wr_data_q <= fifo_data[head_q];
        end
        cnt_q <= cnt_q + CW'(enq) - CW'(deq);
      end
    end
  end

  // buffer storage; contents are meaningless outside [head, head+count)
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_inst[tail_q] <= e1_inst_q;
      fifo_addr[tail_q] <= e1_addr_q;
      fifo_data[tail_q] <= new_val;
    end
  end

  assign prf_raddr           = raddr_q;
  assign CSR_result_valid    = vld_pipe_q[1];
  assign CSR_result_dest     = res_dest_q;
  assign CSR_result_data     = res_data_q;
  assign CSR_result_inst_num = res_inst_q;
  assign csr_wr_en           = wr_en_q;
  assign csr_wr_addr         = wr_addr_q;
  assign csr_wr_data         = wr_data_q;
  assign csr_overflow        = ovf_q;
endmodule

// File: tb/tb_csr_exec_unit.sv
// tb_csr_exec_unit: table vectors, directed corner sequences and a random run,
// all shadowed cycle by cycle by a queue-based reference model.
module tb_csr_exec_unit;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [129:0] issue_pkt;
  logic [7:0]   prf_raddr;
  logic [31:0]  prf_rdata;
  logic         CSR_result_valid;
  logic [7:0]   CSR_result_dest;
  logic [31:0]  CSR_result_data, CSR_result_inst_num;
  logic         commit_valid;
  logic [31:0]  commit_inst_num;
  logic         flush;
  logic         csr_wr_en;
  logic [11:0]  csr_wr_addr;
  logic [31:0]  csr_wr_data;
  logic         csr_busy, csr_overflow;

  logic [31:0]  prf_mem [256];
  assign prf_rdata = prf_mem[prf_raddr];

  csr_exec_unit #(.DEPTH(DEPTH), .PHY_W(8)) dut (
    .clk(clk), .reset(reset), .issue_pkt(issue_pkt),
    .prf_raddr(prf_raddr), .prf_rdata(prf_rdata),
    .CSR_result_valid(CSR_result_valid), .CSR_result_dest(CSR_result_dest),
    .CSR_result_data(CSR_result_data), .CSR_result_inst_num(CSR_result_inst_num),
    .commit_valid(commit_valid), .commit_inst_num(commit_inst_num), .flush(flush),
    .csr_wr_en(csr_wr_en), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
    .csr_busy(csr_busy), .csr_overflow(csr_overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] inst;
    logic [11:0] addr;
    logic [31:0] data;
  } ent_t;
  typedef struct {
    bit          v;
    logic [31:0] inst;
    logic [7:0]  rd;
    logic [3:0]  op;
    bit          s2;
    logic [31:0] csr;
    logic [11:0] addr;
    logic [31:0] imm;
  } e1_t;

  ent_t        mq[$];
  e1_t         m_e1;
  logic [7:0]  m_raddr, m_rdest;
  bit          m_rv, m_wen, m_ovf;
  logic [31:0] m_rdata, m_rinst, m_wdata;
  logic [11:0] m_waddr;

  task automatic model_reset();
    mq.delete();
    m_e1.v = 0; m_raddr = '0; m_rv = 0; m_rdest = '0; m_rdata = '0; m_rinst = '0;
    m_wen = 0; m_waddr = '0; m_wdata = '0; m_ovf = 0;
  endtask

  function automatic bit model_busy();
    return (mq.size() + int'(m_e1.v) + int'(m_rv)) >= DEPTH;
  endfunction

  task automatic model_step();
    bit          busy, w;
    logic [31:0] src, nv;
    busy = model_busy();
    if (flush) begin
      mq.delete();
      m_wen = 0;
    end else if (commit_valid && mq.size() > 0 && mq[0].inst == commit_inst_num) begin
      m_wen = 1; m_waddr = mq[0].addr; m_wdata = mq[0].data;
      void'(mq.pop_front());
    end else m_wen = 0;
    m_rv = m_e1.v && !flush;
    if (m_rv) begin
      src = m_e1.s2 ? (m_e1.imm & 32'h1F) : prf_mem[m_raddr];
      nv = src; w = 0;
      case (m_e1.op)
        4'd0: begin nv = src; w = 1; end
        4'd1: begin nv = m_e1.csr | src; w = (src != 0); end
        4'd2: begin nv = m_e1.csr & ~src; w = (src != 0); end
        default: w = 0;
      endcase
      m_rdest = m_e1.rd; m_rdata = m_e1.csr; m_rinst = m_e1.inst;
      if (w) mq.push_back('{m_e1.inst, m_e1.addr, nv});
    end
    if (issue_pkt[129] && busy) m_ovf = 1;
    m_e1.v = issue_pkt[129] && !busy && !flush;
    if (m_e1.v) begin
      m_raddr   = issue_pkt[128:121];
      m_e1.inst = issue_pkt[120:89];
      m_e1.rd   = issue_pkt[88:81];
      m_e1.op   = issue_pkt[80:77];
      m_e1.s2   = issue_pkt[76];
      m_e1.csr  = issue_pkt[75:44];
      m_e1.addr = issue_pkt[43:32];
      m_e1.imm  = issue_pkt[31:0];
    end
  endtask

  task automatic check_all();
    chk("m_raddr", {24'b0, prf_raddr}, {24'b0, m_raddr});
    chk("m_res_valid", {31'b0, CSR_result_valid}, {31'b0, m_rv});
    if (m_rv) begin
      chk("m_res_dest", {24'b0, CSR_result_dest}, {24'b0, m_rdest});
      chk("m_res_data", CSR_result_data, m_rdata);
      chk("m_res_inst", CSR_result_inst_num, m_rinst);
    end
    chk("m_wr_en", {31'b0, csr_wr_en}, {31'b0, m_wen});
    if (m_wen) begin
      chk("m_wr_addr", {20'b0, csr_wr_addr}, {20'b0, m_waddr});
      chk("m_wr_data", csr_wr_data, m_wdata);
    end
    chk("m_busy", {31'b0, csr_busy}, {31'b0, model_busy()});
    chk("m_overflow", {31'b0, csr_overflow}, {31'b0, m_ovf});
  endtask

  // one clock: model follows the edge, outputs compared on the falling edge,
  // then single-cycle strobes are dropped
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    issue_pkt = '0; commit_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic issue(input logic [31:0] inst, input logic [7:0] rd, input logic [7:0] op1,
                       input logic [3:0] op, input logic s2, input logic [31:0] csr,
                       input logic [11:0] addr, input logic [31:0] imm);
    issue_pkt = {1'b1, op1, inst, rd, op, s2, csr, addr, imm};
  endtask

  task automatic commit(input logic [31:0] inst);
    commit_valid = 1'b1; commit_inst_num = inst;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [3:0]  op;
    logic        s2;
    logic [31:0] imm;
    logic [31:0] prf;
    logic [31:0] csr;
    logic        exp_wr;
    logic [31:0] exp_new;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[11];
    int   next_inst;
    vt[0]  = '{4'd0, 1'b0, 32'h0,        32'hAAAA5555, 32'h11,       1'b1, 32'hAAAA5555};
    vt[1]  = '{4'd1, 1'b1, 32'h3,        32'h0,        32'h8,        1'b1, 32'hB};
    vt[2]  = '{4'd1, 1'b1, 32'h0,        32'h5,        32'h8,        1'b0, 32'h0};
    vt[3]  = '{4'd2, 1'b0, 32'h0,        32'hF0,       32'hFF,       1'b1, 32'h0F};
    vt[4]  = '{4'd2, 1'b0, 32'h0,        32'h0,        32'hFF,       1'b0, 32'h0};
    vt[5]  = '{4'd0, 1'b1, 32'hFFFFFFE7, 32'h0,        32'h0,        1'b1, 32'h7};
    vt[6]  = '{4'd0, 1'b0, 32'h0,        32'h0,        32'h55,       1'b1, 32'h0};
    vt[7]  = '{4'd3, 1'b0, 32'h0,        32'h5,        32'h1234,     1'b0, 32'h0};
    vt[8]  = '{4'd15,1'b0, 32'h0,        32'h5,        32'h1234,     1'b0, 32'h0};
    vt[9]  = '{4'd1, 1'b0, 32'h0,        32'h0F000000, 32'h000000F0, 1'b1, 32'h0F0000F0};
    vt[10] = '{4'd2, 1'b1, 32'h1F,       32'h0,        32'hFFFFFFFF, 1'b1, 32'hFFFFFFE0};

    for (int i = 0; i < 256; i++) prf_mem[i] = 32'h0;
    reset = 1'b1; issue_pkt = '0; commit_valid = 1'b0; commit_inst_num = '0; flush = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_raddr", {24'b0, prf_raddr}, 32'h0);
    chk("rst_res_valid", {31'b0, CSR_result_valid}, 32'h0);
    chk("rst_res_data", CSR_result_data, 32'h0);
    chk("rst_wr_en", {31'b0, csr_wr_en}, 32'h0);
    chk("rst_busy", {31'b0, csr_busy}, 32'h0);
    chk("rst_overflow", {31'b0, csr_overflow}, 32'h0);
    reset = 1'b0;
    cyc();

    // table: one instruction at a time, broadcast two cycles after issue, then commit
    for (int i = 0; i < 11; i++) begin
      prf_mem[8'h20 + i] = vt[i].prf;
      issue(32'd5 + i, 8'h12 + 8'(i), 8'h20 + 8'(i), vt[i].op, vt[i].s2, vt[i].csr,
            12'h300 + 12'(i), vt[i].imm);
      cyc();
      cyc();
      chk("tbl_res_valid", {31'b0, CSR_result_valid}, 32'h1);
      chk("tbl_res_dest", {24'b0, CSR_result_dest}, 32'h12 + i);
      chk("tbl_res_data", CSR_result_data, vt[i].csr);
      chk("tbl_res_inst", CSR_result_inst_num, 32'd5 + i);
      cyc();
      commit(32'd5 + i);
      cyc();
      chk("tbl_wr_en", {31'b0, csr_wr_en}, {31'b0, vt[i].exp_wr});
      if (vt[i].exp_wr) begin
        chk("tbl_wr_addr", {20'b0, csr_wr_addr}, 32'h300 + i);
        chk("tbl_wr_data", csr_wr_data, vt[i].exp_new);
      end
      cyc();
    end

    // commit that does not match the head is ignored
    issue(32'd200, 8'h1, 8'h0, 4'd0, 1'b1, 32'h0, 12'h100, 32'h4);
    cyc(); cyc(); cyc();
    issue(32'd201, 8'h2, 8'h0, 4'd0, 1'b1, 32'h0, 12'h101, 32'h5);
    cyc(); cyc(); cyc();
    commit(32'd201);
    cyc();
    chk("nonhead_wr_en", {31'b0, csr_wr_en}, 32'h0);
    commit(32'd200);
    cyc();
    chk("head_wr_data", csr_wr_data, 32'h4);
    commit(32'd201);
    cyc();
    chk("second_wr_data", csr_wr_data, 32'h5);
    cyc();

    // fill the buffer, then a dropped issue sets overflow
    for (int k = 0; k < 4; k++) begin
      issue(32'd210 + k, 8'h3, 8'h0, 4'd0, 1'b1, 32'h0, 12'h200, 32'(k + 1));
      cyc(); cyc(); cyc();
    end
    chk("full_busy", {31'b0, csr_busy}, 32'h1);
    issue(32'd299, 8'h4, 8'h0, 4'd0, 1'b1, 32'h0, 12'h200, 32'h9);
    cyc();
    chk("drop_overflow", {31'b0, csr_overflow}, 32'h1);
    cyc();
    chk("drop_no_bcast", {31'b0, CSR_result_valid}, 32'h0);
    commit(32'd210);
    cyc();
    chk("unfull_busy", {31'b0, csr_busy}, 32'h0);
    for (int k = 1; k < 4; k++) begin
      commit(32'd210 + k);
      cyc();
    end
    cyc();

    // wrap: three entries, then enqueue and dequeue on the same edge, eight times
    pulse_reset();
    for (int k = 0; k < 3; k++) begin
      issue(32'd300 + k, 8'h5, 8'h0, 4'd0, 1'b1, 32'h0, 12'h340 + 12'(k), 32'(k + 1));
      cyc(); cyc(); cyc();
    end
    for (int i = 0; i < 8; i++) begin
      issue(32'd303 + i, 8'h5, 8'h0, 4'd0, 1'b1, 32'h0, 12'h343 + 12'(i), 32'(i + 4));
      cyc();
      commit(32'd300 + i);
      cyc();
      chk("wrap_wr_en", {31'b0, csr_wr_en}, 32'h1);
      chk("wrap_wr_data", csr_wr_data, 32'(i + 1));
      cyc();
    end
    for (int i = 8; i < 11; i++) begin
      commit(32'd300 + i);
      cyc();
      chk("drain_wr_data", csr_wr_data, 32'(i + 1));
    end
    cyc();

    // flush: entries pending and one instruction headed for E2
    for (int k = 0; k < 3; k++) begin
      issue(32'd400 + k, 8'h6, 8'h0, 4'd0, 1'b1, 32'h0, 12'h500, 32'(k + 16));
      cyc(); cyc(); cyc();
    end
    issue(32'd403, 8'h6, 8'h0, 4'd0, 1'b1, 32'h0, 12'h500, 32'h3);
    commit(32'd400);
    cyc();
    chk("pre_flush_wr_en", {31'b0, csr_wr_en}, 32'h1);
    chk("pre_flush_wr_data", csr_wr_data, 32'd16);
    flush = 1'b1;
    cyc();
    chk("flush_no_bcast", {31'b0, CSR_result_valid}, 32'h0);
    chk("flush_busy", {31'b0, csr_busy}, 32'h0);
    cyc();
    commit(32'd401);
    cyc();
    chk("flush_commit1", {31'b0, csr_wr_en}, 32'h0);
    commit(32'd402);
    cyc();
    chk("flush_commit2", {31'b0, csr_wr_en}, 32'h0);

    // asynchronous reset while E1 is busy and a write is in flight
    issue(32'd500, 8'h7, 8'h0, 4'd0, 1'b1, 32'h0, 12'h600, 32'h2);
    cyc(); cyc(); cyc();
    issue(32'd501, 8'h8, 8'h33, 4'd0, 1'b0, 32'h77, 12'h601, 32'h0);
    commit(32'd500);
    cyc();
    #2 reset = 1'b1;
    #1;
    chk("arst_raddr", {24'b0, prf_raddr}, 32'h0);
    chk("arst_wr_en", {31'b0, csr_wr_en}, 32'h0);
    chk("arst_wr_data", csr_wr_data, 32'h0);
    chk("arst_res_data", CSR_result_data, 32'h0);
    chk("arst_res_inst", CSR_result_inst_num, 32'h0);
    chk("arst_busy", {31'b0, csr_busy}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    cyc();
    commit(32'd501);
    cyc();
    chk("arst_no_write", {31'b0, csr_wr_en}, 32'h0);

    // random traffic against the model
    for (int i = 0; i < 256; i++) prf_mem[i] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
    next_inst = 1000;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 1) == 1) begin
        issue(32'(next_inst), 8'($urandom), 8'($urandom), 4'($urandom_range(0, 3)),
              1'($urandom), $urandom, 12'($urandom),
              ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
        next_inst++;
      end
      if ($urandom_range(0, 9) < 4) begin
        if (mq.size() > 0 && $urandom_range(0, 3) != 0) commit(mq[0].inst);
        else commit(32'(next_inst + 5000));
      end
      if ($urandom_range(0, 49) == 0) flush = 1'b1;
      if ($urandom_range(0, 7) == 0) prf_mem[$urandom_range(0, 255)] = $urandom;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
